// File: rtl/clk_rst_pkg.sv
// rtl/clk_rst_pkg.sv - shared types and default parameters for the reset/lock sequencer
package clk_rst_pkg;

   typedef enum logic [2:0] {
      S_MMCM_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } seq_state_t;

   localparam int unsigned DEF_RESET_CYCLES  = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_MAX_RETRIES   = 3;
   localparam int unsigned DEF_SYNC_STAGES   = 2;

   // Counter width covering the largest terminal count; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchronizer with synchronous clear
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic clear_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - MMCM reset/lock sequencer; CLK_RST_SEQ_LOCK_LOSS_CNT_EN adds a lock-loss counter
module clk_rst_seq
   import clk_rst_pkg::*;
#(
   parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic                               i_locked,
   input  logic                               i_restart,
   output logic                               o_mmcm_reset,
   output logic                               o_sys_reset,
   output logic                               o_ready,
   output logic                               o_fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_count,
   output logic [7:0]                         o_lock_loss_count
);

   localparam int unsigned CNT_W = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int unsigned RTY_W = $clog2(MAX_RETRIES+1);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             mmcm_q, sys_q, ready_q, fault_q;
   logic             lock_s;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_i   (i_clk),
      .clear_i (i_reset),
      .d_i     (i_locked),
      .q_o     (lock_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      case (state_q)
         S_MMCM_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TMO_LAST) begin
               retry_d = (retry_q == RTY_MAX) ? retry_q : retry_q + 1'b1;
               state_d = (32'(retry_q) + 32'd1 == MAX_RETRIES) ? S_FAULT : S_MMCM_RST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STABLE: begin
            // A lock dropout restarts the timeout window without charging a retry.
            if (!lock_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_MMCM_RST;
            cnt_d   = '0;
         end
      endcase
      if (i_restart) begin
         state_d = S_MMCM_RST;
         cnt_d   = '0;
         retry_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_MMCM_RST;
         cnt_q   <= '0;
         retry_q <= '0;
         mmcm_q  <= 1'b1;
         sys_q   <= 1'b1;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         mmcm_q  <= (state_q == S_MMCM_RST);
         sys_q   <= (state_q != S_RUN);
         ready_q <= (state_q == S_RUN);
         fault_q <= (state_q == S_FAULT);
      end
   end

   assign o_mmcm_reset  = mmcm_q;
   assign o_sys_reset   = sys_q;
   assign o_ready       = ready_q;
   assign o_fault       = fault_q;
   assign o_retry_count = retry_q;

`ifdef CLK_RST_SEQ_LOCK_LOSS_CNT_EN
   logic [7:0] loss_q;

   // Survives i_restart so lock-loss history spans re-sequences.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         loss_q <= 8'd0;
      end else if (state_q == S_RUN && state_d == S_STABLE && loss_q != 8'hFF) begin
         loss_q <= loss_q + 8'd1;
      end
   end

   assign o_lock_loss_count = loss_q;
`else
   assign o_lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - self-checking bench for clk_rst_seq with timing model from cycle arithmetic
module tb_clk_rst_seq;

   localparam int RC  = 4;
   localparam int LT  = 20;
   localparam int SC  = 8;
   localparam int MR  = 3;
   localparam int SS  = 2;
   localparam int P   = RC + LT;
   localparam int LAT = SS + SC + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       locked;
   logic       restart;
   logic       mmcm_rst, sys_rst, ready, fault;
   logic [1:0] retry;
   logic [7:0] loss;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   clk_rst_seq #(
      .RESET_CYCLES  (RC),
      .LOCK_TIMEOUT  (LT),
      .STABLE_CYCLES (SC),
      .MAX_RETRIES   (MR),
      .SYNC_STAGES   (SS)
   ) dut (
      .i_clk             (clk),
      .i_reset           (rst),
      .i_locked          (locked),
      .i_restart         (restart),
      .o_mmcm_reset      (mmcm_rst),
      .o_sys_reset       (sys_rst),
      .o_ready           (ready),
      .o_fault           (fault),
      .o_retry_count     (retry),
      .o_lock_loss_count (loss)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mmcm"}, mmcm_rst, 1);
      chk({tag, "_sys"}, sys_rst, 1);
      chk({tag, "_ready"}, ready, 0);
      chk({tag, "_fault"}, fault, 0);
      chk({tag, "_retry"}, retry, 0);
      chk({tag, "_loss"}, loss, 0);
   endtask

   // Raise lock; optionally drop it for the single edge j after the rising edge.
   task automatic lock_and_measure(input int j, output int lat);
      locked = 1'b1;
      step();
      lat = 0;
      while (sys_rst !== 1'b0 && lat < 200) begin
         if (lat == j - 1) locked = 1'b0;
         else if (lat == j) locked = 1'b1;
         step();
         lat++;
      end
   endtask

   task automatic reset_and_wait_lock_phase();
      locked = 1'b0;
      rst    = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < RC + 2; i++) step();
   endtask

   // Sequence with lock never arriving: 0 = MMCM reset, 1 = waiting, 2 = fault.
   function automatic int st_at(input int t);
      if (t >= MR * P) return 2;
      return ((t % P) < RC) ? 0 : 1;
   endfunction

   initial begin
      int n, lat, dly, j, d, st;
      rst     = 1'b1;
      locked  = 1'b0;
      restart = 1'b0;

      step();
      step();
      chk_reset_vals("rst");
      rst = 1'b0;
      step();
      chk_reset_vals("post_rst");
      n = 1;
      for (int t = 2; t <= RC + 2; t++) begin
         step();
         if (mmcm_rst === 1'b1) n++;
      end
      chk("t1_mmcm_width", n, RC);
      chk("t1_mmcm_low", mmcm_rst, 0);

      dly = 10 - (RC + 2) + int'($urandom_range(0, 5));
      for (int i = 0; i < dly; i++) step();
      lock_and_measure(-1, lat);
      chk("t1_latency", lat, LAT);
      chk("t1_ready", ready, 1);
      chk("t1_retry", retry, 0);
      chk("t1_fault", fault, 0);

      reset_and_wait_lock_phase();
      lock_and_measure(6, lat);
      chk("t3_glitch5_latency", lat, 6 + 1 + LAT);
      chk("t3_retry", retry, 0);

      reset_and_wait_lock_phase();
      j = int'($urandom_range(1, SC));
      lock_and_measure(j, lat);
      chk("t3_glitch_rand_latency", lat, j + 1 + LAT);
      chk("t3_ready", ready, 1);

      d = int'($urandom_range(2, 6));
      locked = 1'b0;
      step();
      lat = 0;
      while (lat < 200) begin
         if (lat == d - 1) locked = 1'b1;
         step();
         lat++;
         if (lat == 3) begin
            chk("t4_sys_reasserted", sys_rst, 1);
            chk("t4_ready_dropped", ready, 0);
         end
         if (lat > 3 && sys_rst === 1'b0) break;
      end
      chk("t4_relock_latency", lat, d + LAT);
      chk("t4_ready", ready, 1);
`ifdef CLK_RST_SEQ_LOCK_LOSS_CNT_EN
      chk("t4_loss", loss, 1);
`else
      chk("t4_loss", loss, 0);
`endif

      locked = 1'b0;
      rst    = 1'b1;
      step();
      rst = 1'b0;
      for (int t = 1; t <= MR * P + 4; t++) begin
         step();
         st = st_at(t - 1);
         chk($sformatf("t2_mmcm@%0d", t), mmcm_rst, (st == 0) ? 1 : 0);
         chk($sformatf("t2_fault@%0d", t), fault, (st == 2) ? 1 : 0);
         chk($sformatf("t2_sys@%0d", t), sys_rst, 1);
         chk($sformatf("t2_retry@%0d", t), retry, (t / P < MR) ? t / P : MR);
      end

      locked = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("t5_fault_sticky", fault, 1);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("t5_retry_clear", retry, 0);
      lat = 0;
      n   = 0;
      while (ready !== 1'b1 && lat < 200) begin
         step();
         lat++;
         if (mmcm_rst === 1'b1) n++;
      end
      chk("t5_mmcm_width", n, RC);
      chk("t5_ready_latency", lat, RC + SC + 2);
      chk("t5_sys", sys_rst, 0);
      chk("t5_fault", fault, 0);
`ifdef CLK_RST_SEQ_LOCK_LOSS_CNT_EN
      chk("t5_loss_kept", loss, 1);
`else
      chk("t5_loss_kept", loss, 0);
`endif

      rst     = 1'b1;
      restart = 1'b1;
      step();
      chk_reset_vals("t6");
      rst     = 1'b0;
      restart = 1'b0;
      step();
      chk_reset_vals("t6_after");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
